// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, default widths and saturating counter helpers for the branch predictor
package bp_pkg;

    localparam int BP_ADDR_W   = 16;
    localparam int BP_IDX_W    = 6;
    localparam int BP_TAG_W    = 4;
    localparam int BP_CTR_W    = 2;
    localparam int BP_INFLIGHT = 4;

    typedef struct packed {
        logic                 valid;
        logic [BP_TAG_W-1:0]  tag;
        logic [BP_ADDR_W-1:0] target;
        logic [BP_CTR_W-1:0]  ctr;
    } btb_entry_t;

    typedef struct packed {
        logic [BP_ADDR_W-1:0] pc;
        logic                 pred_taken;
        logic [BP_ADDR_W-1:0] pred_target;
        logic [BP_IDX_W-1:0]  ctr_idx;
        logic [BP_IDX_W-1:0]  pc_idx;
    } inflight_t;

    function automatic logic [BP_CTR_W-1:0] ctr_thr();
        return BP_CTR_W'(1) << (BP_CTR_W - 1);
    endfunction

    function automatic logic [BP_CTR_W-1:0] ctr_inc(input logic [BP_CTR_W-1:0] c);
        return (c == '1) ? c : c + BP_CTR_W'(1);
    endfunction

    function automatic logic [BP_CTR_W-1:0] ctr_dec(input logic [BP_CTR_W-1:0] c);
        return (c == '0) ? c : c - BP_CTR_W'(1);
    endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// rtl/btb_predictor_if.sv - lookup (ID) and resolve (MEM) signal bundle for btb_predictor
interface btb_predictor_if #(
    parameter int ADDR_W = 16
);
    logic              lk_valid;
    logic [ADDR_W-1:0] lk_pc;
    logic              lk_ready;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              rs_valid;
    logic              rs_taken;
    logic [ADDR_W-1:0] rs_target;
    logic              mispredict;
    logic              mp_target;
    logic [ADDR_W-1:0] redirect_pc;
    logic              rs_orphan;

    modport master (
        output lk_valid, lk_pc, rs_valid, rs_taken, rs_target,
        input  lk_ready, pred_taken, pred_target, mispredict, mp_target, redirect_pc, rs_orphan
    );

    modport slave (
        input  lk_valid, lk_pc, rs_valid, rs_taken, rs_target,
        output lk_ready, pred_taken, pred_target, mispredict, mp_target, redirect_pc, rs_orphan
    );
endinterface

// File: rtl/bp_inflight_fifo.sv
// rtl/bp_inflight_fifo.sv - in-order queue of unresolved predictions with flush
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  inflight_t        push_data,
    input  logic             pop,
    input  logic             flush,
    output inflight_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    inflight_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - tagged BTB with saturating counters and in-flight check; BTB_GHIST_EN selects gshare counter indexing
module btb_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_W   = BP_ADDR_W,
    parameter int IDX_W    = BP_IDX_W,
    parameter int TAG_W    = BP_TAG_W,
    parameter int CTR_W    = BP_CTR_W,
    parameter int INFLIGHT = BP_INFLIGHT
) (
    input  logic           clk,
    input  logic           reset_n,
    btb_predictor_if.slave bus
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int CNT_W   = $clog2(INFLIGHT + 1);

    btb_entry_t       tbl [ENTRIES];
    inflight_t        push_rec;
    inflight_t        head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] lk_cidx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_ready_i;
    logic             lk_push;
    logic             pred_taken_i;

    logic [TAG_W-1:0] rs_tag;
    logic             rs_fire;
    logic             rs_hit;
    logic             tgt_wrong;
    logic             mispredict_i;

    assign lk_idx = bus.lk_pc[IDX_W-1:0];
    assign lk_tag = bus.lk_pc[IDX_W+TAG_W-1:IDX_W];

`ifdef BTB_GHIST_EN
    logic [IDX_W-1:0] ghr;
    assign lk_cidx = lk_idx ^ ghr;
`else
    assign lk_cidx = lk_idx;
`endif

    // Lookup side reads the table before any resolve write in the same cycle.
    assign lk_hit       = tbl[lk_idx].valid && (tbl[lk_idx].tag == lk_tag);
    assign lk_ready_i   = (fifo_count != CNT_W'(INFLIGHT));
    assign lk_push      = bus.lk_valid & lk_ready_i & ~mispredict_i;
    assign pred_taken_i = lk_push & lk_hit & (tbl[lk_cidx].ctr >= ctr_thr());

    assign push_rec.pc          = bus.lk_pc;
    assign push_rec.pred_taken  = pred_taken_i;
    assign push_rec.pred_target = pred_taken_i ? tbl[lk_idx].target : '0;
    assign push_rec.ctr_idx     = lk_cidx;
    assign push_rec.pc_idx      = lk_idx;

    assign rs_fire      = bus.rs_valid & ~fifo_empty;
    assign rs_tag       = head.pc[IDX_W+TAG_W-1:IDX_W];
    assign rs_hit       = tbl[head.pc_idx].valid && (tbl[head.pc_idx].tag == rs_tag);
    assign tgt_wrong    = head.pred_taken & bus.rs_taken & (head.pred_target != bus.rs_target);
    assign mispredict_i = rs_fire & ((head.pred_taken != bus.rs_taken) | tgt_wrong);

    assign bus.lk_ready    = lk_ready_i;
    assign bus.pred_taken  = pred_taken_i;
    assign bus.pred_target = push_rec.pred_target;
    assign bus.mispredict  = mispredict_i;
    assign bus.mp_target   = rs_fire & tgt_wrong;
    assign bus.redirect_pc = !rs_fire ? '0 : (bus.rs_taken ? bus.rs_target : head.pc);
    assign bus.rs_orphan   = bus.rs_valid & fifo_empty;

    bp_inflight_fifo #(
        .DEPTH (INFLIGHT)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (lk_push),
        .push_data (push_rec),
        .pop       (rs_fire),
        .flush     (mispredict_i),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Tag/target/valid live at pc_idx; the counter lives at ctr_idx (equal unless gshare).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
        end else if (rs_fire) begin
            if (bus.rs_taken) begin
                tbl[head.pc_idx].target <= bus.rs_target;
                if (!rs_hit) begin
                    tbl[head.pc_idx].valid <= 1'b1;
                    tbl[head.pc_idx].tag   <= rs_tag;
                    tbl[head.ctr_idx].ctr  <= ctr_thr();
                end else begin
                    tbl[head.ctr_idx].ctr  <= ctr_inc(tbl[head.ctr_idx].ctr);
                end
            end else if (rs_hit) begin
                tbl[head.ctr_idx].ctr <= ctr_dec(tbl[head.ctr_idx].ctr);
            end
        end
    end

`ifdef BTB_GHIST_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     ghr <= '0;
        else if (rs_fire) ghr <= {ghr[IDX_W-2:0], bus.rs_taken};
    end
`endif

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - directed vector table plus randomized run against a behavioural model
module tb_btb_predictor;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    btb_predictor_if #(.ADDR_W(16)) bus ();

    btb_predictor dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rst;
        bit          lv;
        logic [15:0] pc;
        bit          rv;
        bit          rt;
        logic [15:0] rtgt;
        bit          e_ready;
        bit          e_pt;
        logic [15:0] e_ptgt;
        bit          e_mp;
        bit          e_mpt;
        logic [15:0] e_redir;
        bit          e_orph;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit lv, logic [15:0] pc, bit rv, bit rt, logic [15:0] rtgt,
                                bit rdy, bit pt, logic [15:0] ptgt, bit mp, bit mpt,
                                logic [15:0] redir, bit orph);
        vec_t v;
        v = '{rst, lv, pc, rv, rt, rtgt, rdy, pt, ptgt, mp, mpt, redir, orph};
        vecs.push_back(v);
    endfunction

    function automatic void lk(logic [15:0] pc, bit pt, logic [15:0] ptgt);
        add(0, 1, pc, 0, 0, 16'h0, 1, pt, ptgt, 0, 0, 16'h0, 0);
    endfunction

    function automatic void rs(bit rt, logic [15:0] tgt, bit mp, bit mpt, logic [15:0] redir);
        add(0, 0, 16'h0, 1, rt, tgt, 1, 0, 16'h0, mp, mpt, redir, 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(bit lv, logic [15:0] pc, bit rv, bit rt, logic [15:0] rtgt);
        bus.lk_valid  = lv;
        bus.lk_pc     = pc;
        bus.rs_valid  = rv;
        bus.rs_taken  = rt;
        bus.rs_target = rtgt;
    endtask

    task automatic check_outs(string tag, bit rdy, bit pt, logic [15:0] ptgt, bit mp, bit mpt,
                              logic [15:0] redir, bit orph);
        check({tag, " lk_ready"},    32'(bus.lk_ready),    32'(rdy));
        check({tag, " pred_taken"},  32'(bus.pred_taken),  32'(pt));
        check({tag, " pred_target"}, 32'(bus.pred_target), 32'(ptgt));
        check({tag, " mispredict"},  32'(bus.mispredict),  32'(mp));
        check({tag, " mp_target"},   32'(bus.mp_target),   32'(mpt));
        check({tag, " redirect_pc"}, 32'(bus.redirect_pc), 32'(redir));
        check({tag, " rs_orphan"},   32'(bus.rs_orphan),   32'(orph));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(0, 16'h0, 0, 0, 16'h0);
        #1;
        check("reset lk_ready", 32'(bus.lk_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Behavioural reference: plain arrays indexed by pc mod table size.
    bit m_valid[64];
    int m_tag[64];
    int m_tgt[64];
    int m_ctr[64];
    int m_ghr;
    typedef struct { int pc; bit pt; int tgt; int ci; } mrec_t;
    mrec_t mq[$];

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        m_ghr = 0;
        mq.delete();
    endfunction

    logic [15:0] pcs[6]  = '{16'h0010, 16'h0050, 16'h0410, 16'h0023, 16'h07C5, 16'h0011};
    logic [15:0] tgts[4] = '{16'h0040, 16'h0080, 16'h0200, 16'h1234};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 16'h0, 0, 0, 16'h0);

        // Train / retarget on 0x0010
        add(1, 0, 16'h0, 0, 0, 16'h0, 1, 0, 16'h0, 0, 0, 16'h0, 0);
        lk(16'h0010, 0, 16'h0);
        rs(1, 16'h0040, 1, 0, 16'h0040);
        lk(16'h0010, 1, 16'h0040);
        rs(1, 16'h0040, 0, 0, 16'h0040);
        lk(16'h0010, 1, 16'h0040);
        rs(1, 16'h0080, 1, 1, 16'h0080);
        lk(16'h0010, 1, 16'h0080);
        rs(1, 16'h0080, 0, 0, 16'h0080);
        // Counter saturation on 0x0023: 5 taken then not-taken down to 0
        lk(16'h0023, 0, 16'h0);
        rs(1, 16'h0200, 1, 0, 16'h0200);
        for (int k = 0; k < 4; k++) begin
            lk(16'h0023, 1, 16'h0200);
            rs(1, 16'h0200, 0, 0, 16'h0200);
        end
        lk(16'h0023, 1, 16'h0200);
        rs(0, 16'h0, 1, 0, 16'h0023);
        lk(16'h0023, 1, 16'h0200);
        rs(0, 16'h0, 1, 0, 16'h0023);
        lk(16'h0023, 0, 16'h0);
        rs(0, 16'h0, 0, 0, 16'h0023);
        // FIFO full, fifth lookup dropped, pop does not raise ready same cycle
        add(1, 1, 16'h0001, 0, 0, 16'h0, 1, 0, 16'h0, 0, 0, 16'h0, 0);
        lk(16'h0002, 0, 16'h0);
        lk(16'h0003, 0, 16'h0);
        lk(16'h0004, 0, 16'h0);
        add(0, 1, 16'h0005, 0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 0);
        add(0, 1, 16'h0005, 1, 0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0001, 0);
        add(0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 16'h0, 0, 0, 16'h0, 0);
        rs(0, 16'h0, 0, 0, 16'h0002);
        rs(0, 16'h0, 0, 0, 16'h0003);
        rs(0, 16'h0, 0, 0, 16'h0004);
        add(0, 0, 16'h0, 1, 0, 16'h0, 1, 0, 16'h0, 0, 0, 16'h0, 1);
        // Flush with concurrent lookup, then orphan resolve
        add(1, 1, 16'h0010, 0, 0, 16'h0, 1, 0, 16'h0, 0, 0, 16'h0, 0);
        lk(16'h0011, 0, 16'h0);
        lk(16'h0012, 0, 16'h0);
        add(0, 1, 16'h0013, 1, 1, 16'h0040, 1, 0, 16'h0, 1, 0, 16'h0040, 0);
        add(0, 0, 16'h0, 1, 1, 16'h0300, 1, 0, 16'h0, 0, 0, 16'h0, 1);
        lk(16'h0010, 1, 16'h0040);
        add(0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 16'h0, 0, 0, 16'h0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].lv, vecs[i].pc, vecs[i].rv, vecs[i].rt, vecs[i].rtgt);
            #1;
            check_outs($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_pt, vecs[i].e_ptgt,
                       vecs[i].e_mp, vecs[i].e_mpt, vecs[i].e_redir, vecs[i].e_orph);
            @(negedge clk);
        end

        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            bit lv, rv, rt, ready, fire, orph, mp, mpt, hit, acc, pt;
            logic [15:0] pc, rtgt;
            int idx, tag, ci, redir, ptgt, ri, rtag;
            mrec_t h;
            if (c == 300) begin
                do_reset();
                model_reset();
            end
            lv   = ($urandom_range(0, 99) < 60);
            pc   = pcs[$urandom_range(0, 5)];
            rv   = ($urandom_range(0, 99) < 45);
            rt   = 1'($urandom_range(0, 1));
            rtgt = tgts[$urandom_range(0, 3)];

            ready = (mq.size() != 4);
            fire  = rv && (mq.size() > 0);
            orph  = rv && (mq.size() == 0);
            mp = 0; mpt = 0; redir = 0;
            if (fire) begin
                h     = mq[0];
                mpt   = h.pt && rt && (h.tgt != int'(rtgt));
                mp    = (h.pt != rt) || mpt;
                redir = rt ? int'(rtgt) : h.pc;
            end
            idx = int'(pc) % 64;
            tag = (int'(pc) / 64) % 16;
`ifdef BTB_GHIST_EN
            ci  = idx ^ m_ghr;
`else
            ci  = idx;
`endif
            hit  = m_valid[idx] && (m_tag[idx] == tag);
            acc  = lv && ready && !mp;
            pt   = acc && hit && (m_ctr[ci] >= 2);
            ptgt = pt ? m_tgt[idx] : 0;

            drive(lv, pc, rv, rt, rtgt);
            #1;
            check_outs($sformatf("rnd%0d", c), ready, pt, 16'(ptgt), mp, mpt, 16'(redir), orph);

            if (fire) begin
                ri   = h.pc % 64;
                rtag = (h.pc / 64) % 16;
                if (rt) begin
                    m_tgt[ri] = int'(rtgt);
                    if (!(m_valid[ri] && m_tag[ri] == rtag)) begin
                        m_valid[ri] = 1; m_tag[ri] = rtag; m_ctr[h.ci] = 2;
                    end else if (m_ctr[h.ci] < 3) begin
                        m_ctr[h.ci] = m_ctr[h.ci] + 1;
                    end
                end else if (m_valid[ri] && m_tag[ri] == rtag && m_ctr[h.ci] > 0) begin
                    m_ctr[h.ci] = m_ctr[h.ci] - 1;
                end
                m_ghr = ((m_ghr * 2) + int'(rt)) % 64;
                void'(mq.pop_front());
                if (mp) mq.delete();
            end
            if (acc) mq.push_back('{int'(pc), pt, ptgt, ci});
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
